// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its time base, keypad and display.
// The bench drives the master side and the controller uses the slave side.
interface alarm_controller_if;
  logic       sec_tick;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       en;
  logic       set_al;
  logic       sel_min;
  logic       up_p;
  logic       down_p;
  logic       stop_p;
  logic       snooze_p;
  logic       beep;
  logic [4:0] al_hh;
  logic [5:0] al_mm;
  logic       ringing;
  logic       buzzer;

  modport master (
    output sec_tick, hh, mm, ss, en, set_al, sel_min,
    output up_p, down_p, stop_p, snooze_p, beep,
    input  al_hh, al_mm, ringing, buzzer
  );

  modport slave (
    input  sec_tick, hh, mm, ss, en, set_al, sel_min,
    input  up_p, down_p, stop_p, snooze_p, beep,
    output al_hh, al_mm, ringing, buzzer
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm clock controller: alarm time editing, match detection and the IDLE/RING/SNOOZE FSM.
// Define ALARM_SNOOZE_EN to compile in the snooze state, the snooze counter and snooze_p handling.
module alarm_controller #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input logic               clk,
  input logic               rst_n,
  alarm_controller_if.slave bus
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

`ifdef ALARM_SNOOZE_EN
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_t;
  logic [11:0] snz_cnt_q, snz_cnt_d;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1} state_t;
  logic unused_snooze_s;
  assign unused_snooze_s = bus.snooze_p;
`endif

  state_t     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [4:0] al_hh_q, al_hh_d;
  logic [5:0] al_mm_q, al_mm_d;
  logic       match_q;
  logic       match_s;
  logic       trigger_s;

  assign match_s   = (bus.hh == al_hh_q) && (bus.mm == al_mm_q) && (bus.ss == 6'd0);
  assign trigger_s = match_s && !match_q;

  // Register bank; match_q resets high so 00:00:00 right after reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= 8'd0;
      al_hh_q    <= 5'd0;
      al_mm_q    <= 6'd0;
      match_q    <= 1'b1;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= 12'd0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      al_hh_q    <= al_hh_d;
      al_mm_q    <= al_mm_d;
      match_q    <= match_s;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  // Alarm time editing; simultaneous up and down cancel each other.
  always_comb begin
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    if (bus.set_al && (bus.up_p != bus.down_p)) begin
      if (bus.sel_min) begin
        if (bus.up_p) begin
          al_mm_d = (al_mm_q == 6'd59) ? 6'd0 : al_mm_q + 6'd1;
        end else begin
          al_mm_d = (al_mm_q == 6'd0) ? 6'd59 : al_mm_q - 6'd1;
        end
      end else begin
        if (bus.up_p) begin
          al_hh_d = (al_hh_q == 5'd23) ? 5'd0 : al_hh_q + 5'd1;
        end else begin
          al_hh_d = (al_hh_q == 5'd0) ? 5'd23 : al_hh_q - 5'd1;
        end
      end
    end else begin
      al_hh_d = al_hh_q;
      al_mm_d = al_mm_q;
    end
  end

  // Next-state logic; disarm or edit mode overrides every other transition.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    if (!bus.en || bus.set_al) begin
      state_d    = ST_IDLE;
      ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d  = 12'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger_s) begin
            state_d    = ST_RING;
            ring_cnt_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RING: begin
          if (bus.stop_p) begin
            state_d    = ST_IDLE;
            ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.snooze_p) begin
            state_d    = ST_SNOOZE;
            ring_cnt_d = 8'd0;
            snz_cnt_d  = SNOOZE_LOAD;
`endif
          end else if (bus.sec_tick) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d    = ST_IDLE;
              ring_cnt_d = 8'd0;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
          end else begin
            state_d = ST_RING;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (bus.stop_p) begin
            state_d   = ST_IDLE;
            snz_cnt_d = 12'd0;
          end else if (bus.sec_tick) begin
            if (snz_cnt_q <= 12'd1) begin
              state_d    = ST_RING;
              ring_cnt_d = 8'd0;
              snz_cnt_d  = 12'd0;
            end else begin
              snz_cnt_d = snz_cnt_q - 12'd1;
            end
          end else begin
            state_d = ST_SNOOZE;
          end
        end
`endif
        default: begin
          state_d    = ST_IDLE;
          ring_cnt_d = 8'd0;
        end
      endcase
    end
  end

  assign bus.al_hh   = al_hh_q;
  assign bus.al_mm   = al_mm_q;
  assign bus.ringing = (state_q == ST_RING);
  assign bus.buzzer  = (state_q == ST_RING) && bus.beep;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: expectations are queued as stimulus is applied
// and popped against the DUT outputs once the corresponding clock edge has passed.
module tb_alarm_controller;

  localparam int SIG_HH   = 0;
  localparam int SIG_MM   = 1;
  localparam int SIG_RING = 2;
  localparam int SIG_BUZZ = 3;

  typedef struct {
    string tag;
    int    sig;
    int    exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  alarm_controller_if bus_if ();

  alarm_controller #(
    .RING_SEC   (60),
    .SNOOZE_MIN (5)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input int sig);
    case (sig)
      SIG_HH:   observe = int'(bus_if.al_hh);
      SIG_MM:   observe = int'(bus_if.al_mm);
      SIG_RING: observe = int'(bus_if.ringing);
      SIG_BUZZ: observe = int'(bus_if.buzzer);
      default:  observe = -1;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input int exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_up();
    bus_if.up_p = 1'b1;
    tick();
    bus_if.up_p = 1'b0;
  endtask

  task automatic pulse_down();
    bus_if.down_p = 1'b1;
    tick();
    bus_if.down_p = 1'b0;
  endtask

  task automatic sec();
    bus_if.sec_tick = 1'b1;
    tick();
    bus_if.sec_tick = 1'b0;
  endtask

  // Produce a fresh rising edge of the match with the alarm at 06:30.
  task automatic retrig();
    bus_if.ss = 6'd1;
    tick();
    bus_if.ss = 6'd0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.sec_tick = 1'b0;
    bus_if.hh       = 5'd0;
    bus_if.mm       = 6'd0;
    bus_if.ss       = 6'd0;
    bus_if.en       = 1'b0;
    bus_if.set_al   = 1'b0;
    bus_if.sel_min  = 1'b0;
    bus_if.up_p     = 1'b0;
    bus_if.down_p   = 1'b0;
    bus_if.stop_p   = 1'b0;
    bus_if.snooze_p = 1'b0;
    bus_if.beep     = 1'b0;

    repeat (2) tick();
    expect_val("rst_al_hh", SIG_HH, 0);
    expect_val("rst_al_mm", SIG_MM, 0);
    expect_val("rst_ringing", SIG_RING, 0);
    expect_val("rst_buzzer", SIG_BUZZ, 0);
    drain();

    rst_n     = 1'b1;
    bus_if.en = 1'b1;
    repeat (3) tick();
    expect_val("no_false_trig_0000", SIG_RING, 0);
    drain();

    // Editing and wrap boundaries
    bus_if.set_al  = 1'b1;
    bus_if.sel_min = 1'b0;
    pulse_down();
    expect_val("hh_wrap_down", SIG_HH, 23);
    drain();
    pulse_up();
    expect_val("hh_wrap_up", SIG_HH, 0);
    drain();
    bus_if.up_p   = 1'b1;
    bus_if.down_p = 1'b1;
    tick();
    bus_if.up_p   = 1'b0;
    bus_if.down_p = 1'b0;
    expect_val("up_down_hh", SIG_HH, 0);
    expect_val("up_down_mm", SIG_MM, 0);
    drain();
    bus_if.set_al = 1'b0;
    pulse_up();
    expect_val("edit_ignored", SIG_HH, 0);
    drain();
    bus_if.set_al  = 1'b1;
    bus_if.sel_min = 1'b1;
    repeat (61) pulse_up();
    expect_val("mm_up61", SIG_MM, 1);
    drain();
    repeat (2) pulse_down();
    expect_val("mm_wrap_down", SIG_MM, 59);
    drain();
    repeat (29) pulse_down();
    expect_val("mm_30", SIG_MM, 30);
    bus_if.sel_min = 1'b0;
    repeat (6) pulse_up();
    expect_val("hh_6", SIG_HH, 6);
    drain();

    // Alarm fires one clock after the match, times out after 60 ticks
    bus_if.set_al = 1'b0;
    bus_if.hh = 5'd6;
    bus_if.mm = 6'd29;
    bus_if.ss = 6'd59;
    tick();
    expect_val("pre_match", SIG_RING, 0);
    drain();
    bus_if.mm = 6'd30;
    bus_if.ss = 6'd0;
    tick();
    expect_val("ring_start", SIG_RING, 1);
    drain();
    bus_if.beep = 1'b1;
    #1;
    expect_val("buzz_hi", SIG_BUZZ, 1);
    drain();
    bus_if.beep = 1'b0;
    #1;
    expect_val("buzz_lo", SIG_BUZZ, 0);
    drain();
    repeat (59) sec();
    expect_val("ring_59", SIG_RING, 1);
    drain();
    sec();
    expect_val("ring_timeout", SIG_RING, 0);
    drain();

    // Stop beats snooze in the same clock
    retrig();
    expect_val("retrig_1", SIG_RING, 1);
    drain();
    bus_if.stop_p   = 1'b1;
    bus_if.snooze_p = 1'b1;
    tick();
    bus_if.stop_p   = 1'b0;
    bus_if.snooze_p = 1'b0;
    expect_val("stop_wins", SIG_RING, 0);
    drain();
    tick();
    bus_if.beep = 1'b1;
    #1;
    expect_val("stop_stays_idle", SIG_RING, 0);
    expect_val("buzz_idle", SIG_BUZZ, 0);
    drain();
    bus_if.beep = 1'b0;

    // Disarm aborts and no retrigger while the time is held
    retrig();
    expect_val("retrig_2", SIG_RING, 1);
    drain();
    bus_if.en = 1'b0;
    tick();
    expect_val("en_abort", SIG_RING, 0);
    drain();
    bus_if.en = 1'b1;
    repeat (5) tick();
    expect_val("no_retrig_held", SIG_RING, 0);
    drain();

    // Edit mode aborts a ring
    retrig();
    bus_if.set_al = 1'b1;
    tick();
    expect_val("set_al_abort", SIG_RING, 0);
    drain();
    bus_if.set_al = 1'b0;
    tick();

    // Snooze behaviour depends on the build
    retrig();
    expect_val("retrig_3", SIG_RING, 1);
    drain();
    bus_if.snooze_p = 1'b1;
    tick();
    bus_if.snooze_p = 1'b0;
`ifdef ALARM_SNOOZE_EN
    expect_val("snooze_quiet", SIG_RING, 0);
    drain();
    repeat (299) sec();
    expect_val("snooze_299", SIG_RING, 0);
    drain();
    sec();
    expect_val("snooze_rering", SIG_RING, 1);
    drain();
`else
    expect_val("snooze_ignored", SIG_RING, 1);
    drain();
`endif
    bus_if.stop_p = 1'b1;
    tick();
    bus_if.stop_p = 1'b0;
    expect_val("stop_idle", SIG_RING, 0);
    drain();

    // Asynchronous reset mid-ring
    retrig();
    repeat (10) sec();
    expect_val("ring_before_rst", SIG_RING, 1);
    drain();
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_ring", SIG_RING, 0);
    expect_val("async_rst_hh", SIG_HH, 0);
    expect_val("async_rst_mm", SIG_MM, 0);
    drain();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    expect_val("no_residual_ring", SIG_RING, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
